permutation_round_iterator: RTL and testbench

- Sequential wrapper that holds the 320-bit ASCON state (type_state, 5 x 64-bit words) and iterates the permutation rounds.
- Each cycle it drives the current state and round index into the round datapath: constant_addition, then substitution, then linear diffusion.
- It captures the datapath output back into the state register.
- It sits directly upstream of constant_addition (it supplies registerS_i and round_i) and is the top-level permutation sequencer beneath the ASCON FSM.
- Supports p^a (12 rounds) and p^b (6 rounds).

---
 rtl/permutation_round_iterator.sv | 83 ++++++++
 tb/tb_permutation_round_iterator.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/permutation_round_iterator.sv
// Round sequencer for the ASCON permutation: holds the 320-bit state and feeds it,
// together with the round index, through the external combinational round datapath.
`timescale 1ns/1ps

module permutation_round_iterator #(
    parameter int NB_ROUNDS_A = 12,
    parameter int NB_ROUNDS_B = 6
) (
    input  logic         clock_i,
    input  logic         resetb_i,
    input  logic         start_i,
    input  logic         mode_i,
    input  logic [319:0] state_i,
    output logic [319:0] round_state_o,
    output logic [3:0]   round_o,
    input  logic [319:0] round_state_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [319:0] state_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Both permutation flavours end on round 11; only the starting index differs.
    localparam logic [3:0] FIRST_ROUND_A = 4'(12 - NB_ROUNDS_A);
    localparam logic [3:0] FIRST_ROUND_B = 4'(12 - NB_ROUNDS_B);
    localparam logic [3:0] LAST_ROUND    = 4'd11;

    logic [1:0]   fsm_q,     fsm_d;
    logic [3:0]   counter_q, counter_d;
    logic [319:0] state_q,   state_d;

    always_comb begin
        fsm_d     = fsm_q;
        counter_d = counter_q;
        state_d   = state_q;
        case (fsm_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = state_i;
                    counter_d = mode_i ? FIRST_ROUND_B : FIRST_ROUND_A;
                    fsm_d     = RUN;
                end
            end
            RUN: begin
                state_d = round_state_i;
                if (counter_q == LAST_ROUND) begin
                    fsm_d = DONE;
                end else begin
                    counter_d = counter_q + 4'd1;
                end
            end
            DONE: begin
                fsm_d = IDLE;
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q     <= IDLE;
            counter_q <= 4'd0;
            state_q   <= '0;
        end else begin
            fsm_q     <= fsm_d;
            counter_q <= counter_d;
            state_q   <= state_d;
        end
    end

    // The result port and the datapath feed are the same register; no output mux.
    assign round_state_o = state_q;
    assign state_o       = state_q;
    assign round_o       = counter_q;
    assign busy_o        = (fsm_q == RUN);
    assign done_o        = (fsm_q == DONE);

endmodule

// File: tb/tb_permutation_round_iterator.sv
// Self-checking bench for permutation_round_iterator using a combinational loopback
// round model and a rule-level reference of the final permutation result.
`timescale 1ns/1ps

module tb_permutation_round_iterator;

    logic         clock;
    logic         resetb;
    logic         startI;
    logic         modeI;
    logic [319:0] stateI;
    logic [319:0] roundStateO;
    logic [3:0]   roundO;
    logic [319:0] roundStateI;
    logic         busyO;
    logic         doneO;
    logic [319:0] stateO;
    logic         countMode;

    int compared   = 0;
    int mismatched = 0;

    permutation_round_iterator dut (
        .clock_i       (clock),
        .resetb_i      (resetb),
        .start_i       (startI),
        .mode_i        (modeI),
        .state_i       (stateI),
        .round_state_o (roundStateO),
        .round_o       (roundO),
        .round_state_i (roundStateI),
        .busy_o        (busyO),
        .done_o        (doneO),
        .state_o       (stateO)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ASCON round constant for index r: high nibble 15-r, low nibble r
    function automatic logic [7:0] rc(input logic [3:0] r);
        logic [3:0] hi;
        hi = 4'd15 - r;
        return {hi, r};
    endfunction

    // Stand-in round datapath: word 2 absorbs the round constant; in count mode word 4
    // additionally accumulates (round+1) so skipped or repeated rounds become visible.
    always_comb begin
        roundStateI = roundStateO;
        roundStateI[191:128] = roundStateO[191:128] ^ {56'h0, rc(roundO)};
        if (countMode) begin
            roundStateI[63:0] = roundStateO[63:0] + 64'(roundO) + 64'd1;
        end
    end

    // Reference result: apply every round from the mode's first index up to 11
    function automatic logic [319:0] refModel(input logic m, input logic [319:0] st, input logic cm);
        logic [319:0] res;
        int first;
        res = st;
        first = m ? 6 : 0;
        for (int r = first; r <= 11; r++) begin
            res[191:128] = res[191:128] ^ {56'h0, rc(4'(r))};
            if (cm) res[63:0] = res[63:0] + 64'(r + 1);
        end
        return res;
    endfunction

    task automatic checkOutput(input string name, input logic [319:0] act, input logic [319:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input string name, input logic m, input logic [319:0] st,
                                 input logic cm, input int disturbAt,
                                 input logic [319:0] expState, input int expDone);
        int first;
        int busyCnt;
        int doneCyc;
        first   = m ? 6 : 0;
        busyCnt = 0;
        doneCyc = -1;
        @(negedge clock);
        startI    = 1'b1;
        modeI     = m;
        stateI    = st;
        countMode = cm;
        @(posedge clock);
        for (int c = 1; c <= 40; c++) begin
            #1;
            if (busyO) begin
                checkOutput({name, " round_o"}, 320'(roundO), 320'(first + busyCnt));
                busyCnt++;
            end
            if (doneO) begin
                doneCyc = c;
                break;
            end
            @(negedge clock);
            startI = (c == disturbAt);
            modeI  = ~m;
            stateI = {10{$urandom()}};
            @(posedge clock);
        end
        checkOutput({name, " doneCycle"}, 320'(doneCyc), 320'(expDone));
        checkOutput({name, " busyCycles"}, 320'(busyCnt), 320'(expDone - 1));
        if (doneCyc > 0) begin
            checkOutput({name, " state_o"}, stateO, expState);
            checkOutput({name, " round_state_o"}, roundStateO, expState);
            @(negedge clock);
            startI = 1'b0;
            @(posedge clock);
            #1;
            checkOutput({name, " donePulseWidth"}, 320'(doneO), 320'(0));
            checkOutput({name, " idleBusy"}, 320'(busyO), 320'(0));
            checkOutput({name, " heldResult"}, stateO, expState);
        end
    endtask

    typedef struct {
        logic         mode;
        logic [319:0] st;
        logic         cm;
        int           disturb;
        logic [319:0] exp;
        int           expDone;
    } vec_t;

    localparam logic [319:0] SPEC_IV = {64'h80400c0600000000, 256'h0};
    localparam logic [319:0] MIX_IV  = {64'h0123456789abcdef, 64'hfedcba9876543210,
                                        64'h00000000000000ff, 64'hdeadbeefcafef00d,
                                        64'hffffffffffffffc0};

    vec_t vecs[6];

    initial begin
        // Hand-derived results: the 12 constants XOR to 0x00, rounds 6..11 XOR to 0x11;
        // count mode adds 1+..+12 = 0x4e (wrapping word 4) or 7+..+12 = 0x39.
        vecs[0] = '{1'b0, SPEC_IV, 1'b0, 0, SPEC_IV, 13};
        vecs[1] = '{1'b1, 320'h0, 1'b0, 0, {128'h0, 64'h11, 128'h0}, 7};
        vecs[2] = '{1'b0, MIX_IV, 1'b1, 0,
                    {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h00000000000000ff,
                     64'hdeadbeefcafef00d, 64'h000000000000000e}, 13};
        vecs[3] = '{1'b1, MIX_IV, 1'b1, 0,
                    {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h00000000000000ee,
                     64'hdeadbeefcafef00d, 64'hfffffffffffffff9}, 7};
        vecs[4] = vecs[2];
        vecs[4].disturb = 3;
        vecs[5] = vecs[3];
        vecs[5].disturb = 2;

        resetb    = 1'b0;
        startI    = 1'b1;
        modeI     = 1'b1;
        stateI    = {10{32'hdeadbeef}};
        countMode = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("reset state_o", stateO, 320'h0);
        checkOutput("reset round_state_o", roundStateO, 320'h0);
        checkOutput("reset round_o", 320'(roundO), 320'h0);
        checkOutput("reset busy_o", 320'(busyO), 320'h0);
        checkOutput("reset done_o", 320'(doneO), 320'h0);
        startI = 1'b0;
        resetb = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("idle state_o", stateO, 320'h0);
        checkOutput("idle busy_o", 320'(busyO), 320'h0);

        for (int i = 0; i < 6; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].mode, vecs[i].st, vecs[i].cm,
                          vecs[i].disturb, vecs[i].exp, vecs[i].expDone);
        end

        // Abort at RUN cycle 5: outputs clear at once and the run never reports done
        begin
            logic sawDone;
            sawDone = 1'b0;
            @(negedge clock);
            startI = 1'b1; modeI = 1'b0; stateI = MIX_IV; countMode = 1'b1;
            @(posedge clock);
            @(negedge clock);
            startI = 1'b0;
            repeat (4) @(posedge clock);
            #1;
            resetb = 1'b0;
            #1;
            checkOutput("abort state_o", stateO, 320'h0);
            checkOutput("abort busy_o", 320'(busyO), 320'h0);
            checkOutput("abort round_o", 320'(roundO), 320'h0);
            @(negedge clock);
            resetb = 1'b1;
            for (int c = 0; c < 15; c++) begin
                @(posedge clock);
                #1;
                if (doneO || busyO) sawDone = 1'b1;
            end
            checkOutput("abort noDone", 320'(sawDone), 320'h0);
        end
        applyStimulus("afterAbort", vecs[2].mode, vecs[2].st, vecs[2].cm, 0, vecs[2].exp, 13);

        // Start held high: second permutation begins after one IDLE cycle
        begin
            int done1, done2, rise2, prevBusy;
            logic [3:0] riseRound;
            done1 = -1; done2 = -1; rise2 = -1; prevBusy = 0; riseRound = 4'hf;
            @(negedge clock);
            startI = 1'b1; modeI = 1'b0; stateI = MIX_IV; countMode = 1'b1;
            @(posedge clock);
            for (int c = 1; c <= 60 && done2 < 0; c++) begin
                #1;
                if (doneO && done1 < 0) done1 = c;
                else if (doneO) done2 = c;
                if (busyO && !prevBusy && done1 > 0 && rise2 < 0) begin
                    rise2 = c;
                    riseRound = roundO;
                end
                prevBusy = busyO;
                if (done2 > 0) begin
                    checkOutput("b2b secondResult", stateO, refModel(1'b0, MIX_IV, 1'b1));
                end
                @(negedge clock);
                if (done2 > 0) startI = 1'b0;
                @(posedge clock);
            end
            startI = 1'b0;
            checkOutput("b2b firstDone", 320'(done1), 320'(13));
            checkOutput("b2b idleGapAfterDone", 320'(rise2), 320'(done1 + 2));
            checkOutput("b2b restartRound", 320'(riseRound), 320'h0);
            checkOutput("b2b secondDone", 320'(done2), 320'(27));
            repeat (2) @(posedge clock);
        end

        for (int i = 0; i < 16; i++) begin
            logic         m, cm;
            logic [319:0] st;
            m  = 1'($urandom_range(0, 1));
            cm = 1'($urandom_range(0, 1));
            for (int w = 0; w < 10; w++) st[w*32 +: 32] = $urandom();
            applyStimulus($sformatf("rand%0d", i), m, st, cm, int'($urandom_range(0, 5)),
                          refModel(m, st, cm), m ? 7 : 13);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
